// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for EX-stage forwarding: select encoding, shadow stage tags
// and the source-vs-tag match rule used by every operand comparator.
package forward_hazard_unit_pkg;

    localparam int TAG_RD_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                we;
        logic                is_load;
    } stage_tag_t;

    localparam stage_tag_t STAGE_TAG_NONE = '{valid: 1'b0, rd: 5'd0, we: 1'b0, is_load: 1'b0};

    // x0 is hard-wired to zero, so it never counts as a producer.
    function automatic logic tag_match(input stage_tag_t t, input logic [TAG_RD_W-1:0] rs,
                                       input logic use_rs);
        return use_rs & t.valid & t.we & (t.rd == rs) & (rs != '0);
    endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_compare.sv
// One operand's comparator: picks the forwarding source and flags a hit on a
// load still sitting in EX.
module fwd_compare
    import forward_hazard_unit_pkg::*;
(
    input  logic [TAG_RD_W-1:0] i_rs,
    input  logic                i_use_rs,
    input  stage_tag_t          i_tag_ex,
    input  stage_tag_t          i_tag_mem,
    output fwd_sel_t            o_next_sel,
    output logic                o_load_hit
);

    logic w_hit_ex;
    logic w_hit_mem;

    assign w_hit_ex   = tag_match(i_tag_ex, i_rs, i_use_rs);
    assign w_hit_mem  = tag_match(i_tag_mem, i_rs, i_use_rs);
    assign o_load_hit = w_hit_ex & i_tag_ex.is_load;

    // Youngest producer wins; a load has no data in MEM, so it only ever forwards from WB.
    always_comb begin
        o_next_sel = FWD_NONE;
        if (w_hit_ex && !i_tag_ex.is_load) begin
            o_next_sel = FWD_MEM;
        end else if (w_hit_mem) begin
            o_next_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding select generator and load-use stall detector for the
// 5-stage rv32i pipeline. Optional perf counters under HAZ_PERF_CNT_EN.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_rd,
    input  logic                  ID_rd_we,
    input  logic                  ID_is_load,
    input  logic                  ID_valid,
    input  logic                  ID_use_rs1,
    input  logic                  ID_use_rs2,
    input  logic                  EX_flush,
    input  logic                  mem_stall,
    output logic [SEL_W-1:0]      EX_forwarding_sel1,
    output logic [SEL_W-1:0]      EX_forwarding_sel2,
    output logic                  load_use_stall
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_load_use_cnt,
    output logic [31:0]           perf_fwd_mem_cnt,
    output logic [31:0]           perf_fwd_wb_cnt
`endif
);

    // The retiring tag simply drops off the end of the shift: no comparison
    // ever consults a WB-stage producer, so only EX and MEM are stored.
    stage_tag_t r_tag_ex;
    stage_tag_t r_tag_mem;
    fwd_sel_t   r_sel1;
    fwd_sel_t   r_sel2;

    fwd_sel_t   w_next_sel1;
    fwd_sel_t   w_next_sel2;
    logic       w_load_hit1;
    logic       w_load_hit2;
    stage_tag_t w_tag_id;

    fwd_compare u_cmp_rs1 (
        .i_rs       (ID_rs1),
        .i_use_rs   (ID_use_rs1),
        .i_tag_ex   (r_tag_ex),
        .i_tag_mem  (r_tag_mem),
        .o_next_sel (w_next_sel1),
        .o_load_hit (w_load_hit1)
    );

    fwd_compare u_cmp_rs2 (
        .i_rs       (ID_rs2),
        .i_use_rs   (ID_use_rs2),
        .i_tag_ex   (r_tag_ex),
        .i_tag_mem  (r_tag_mem),
        .o_next_sel (w_next_sel2),
        .o_load_hit (w_load_hit2)
    );

    assign load_use_stall = ID_valid & ~EX_flush & (w_load_hit1 | w_load_hit2);
    assign w_tag_id       = '{valid: ID_valid, rd: ID_rd, we: ID_rd_we, is_load: ID_is_load};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_ex  <= STAGE_TAG_NONE;
            r_tag_mem <= STAGE_TAG_NONE;
            r_sel1    <= FWD_NONE;
            r_sel2    <= FWD_NONE;
        end else if (!mem_stall) begin
            r_tag_mem <= r_tag_ex;
            if (EX_flush || load_use_stall) begin
                r_tag_ex <= STAGE_TAG_NONE;
                r_sel1   <= FWD_NONE;
                r_sel2   <= FWD_NONE;
            end else begin
                r_tag_ex <= w_tag_id;
                r_sel1   <= ID_valid ? w_next_sel1 : FWD_NONE;
                r_sel2   <= ID_valid ? w_next_sel2 : FWD_NONE;
            end
        end
    end

    assign EX_forwarding_sel1 = r_sel1;
    assign EX_forwarding_sel2 = r_sel2;

`ifdef HAZ_PERF_CNT_EN
    logic        w_latch_sels;
    logic [31:0] w_mem_inc;
    logic [31:0] w_wb_inc;

    assign w_latch_sels = ID_valid & ~EX_flush & ~load_use_stall;
    assign w_mem_inc    = 32'(w_next_sel1 == FWD_MEM) + 32'(w_next_sel2 == FWD_MEM);
    assign w_wb_inc     = 32'(w_next_sel1 == FWD_WB) + 32'(w_next_sel2 == FWD_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_use_cnt <= '0;
            perf_fwd_mem_cnt  <= '0;
            perf_fwd_wb_cnt   <= '0;
        end else if (!mem_stall) begin
            perf_load_use_cnt <= perf_load_use_cnt + 32'(load_use_stall);
            if (w_latch_sels) begin
                perf_fwd_mem_cnt <= perf_fwd_mem_cnt + w_mem_inc;
                perf_fwd_wb_cnt  <= perf_fwd_wb_cnt + w_wb_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboarded bench for forward_hazard_unit: directed pipeline scenarios then
// randomized traffic checked against an in-flight instruction model.
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
    logic       ID_rd_we = 1'b0, ID_is_load = 1'b0, ID_valid = 1'b0;
    logic       ID_use_rs1 = 1'b0, ID_use_rs2 = 1'b0;
    logic       EX_flush = 1'b0, mem_stall = 1'b0;
    logic [1:0] EX_forwarding_sel1, EX_forwarding_sel2;
    logic       load_use_stall;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_load_use_cnt, perf_fwd_mem_cnt, perf_fwd_wb_cnt;
    longint      m_lu = 0, m_fm = 0, m_fw = 0;
`endif

    forward_hazard_unit dut (
        .clk                (clk),
        .rst                (rst),
        .ID_rs1             (ID_rs1),
        .ID_rs2             (ID_rs2),
        .ID_rd              (ID_rd),
        .ID_rd_we           (ID_rd_we),
        .ID_is_load         (ID_is_load),
        .ID_valid           (ID_valid),
        .ID_use_rs1         (ID_use_rs1),
        .ID_use_rs2         (ID_use_rs2),
        .EX_flush           (EX_flush),
        .mem_stall          (mem_stall),
        .EX_forwarding_sel1 (EX_forwarding_sel1),
        .EX_forwarding_sel2 (EX_forwarding_sel2),
        .load_use_stall     (load_use_stall)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_load_use_cnt  (perf_load_use_cnt),
        .perf_fwd_mem_cnt   (perf_fwd_mem_cnt),
        .perf_fwd_wb_cnt    (perf_fwd_wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } minstr_t;

    typedef struct {
        int s1;
        int s2;
    } exp_t;

    minstr_t in_ex, in_mem;     // instructions currently in EX and MEM
    exp_t    exp_q[$];
    exp_t    last_exp = '{0, 0};
    int      n_checks = 0;
    int      n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit writes(input minstr_t m, input int rs, input bit u);
        return u && rs != 0 && m.v && m.we && m.rd == rs;
    endfunction

    // Result is in MEM if the producer is an ALU op in EX, in WB if it sits in MEM.
    function automatic int src_of(input int rs, input bit u);
        if (writes(in_ex, rs, u) && !in_ex.ld) return 1;
        if (writes(in_mem, rs, u)) return 2;
        return 0;
    endfunction

    task automatic step(input bit r, input bit iv, input int s1, input int s2, input int d,
                        input bit w, input bit l, input bit u1, input bit u2,
                        input bit f, input bit m);
        bit      st;
        exp_t    e;
        minstr_t nw;
        @(negedge clk);
        rst = r; ID_valid = iv; ID_rs1 = 5'(s1); ID_rs2 = 5'(s2); ID_rd = 5'(d);
        ID_rd_we = w; ID_is_load = l; ID_use_rs1 = u1; ID_use_rs2 = u2;
        EX_flush = f; mem_stall = m;
        #1;
        st = iv && !f && in_ex.ld && (writes(in_ex, s1, u1) || writes(in_ex, s2, u2));
        chk("load_use_stall", load_use_stall, st);
        nw = '{v: iv, rd: d, we: w, ld: l};
        if (r) begin
            in_ex = '{0, 0, 0, 0}; in_mem = '{0, 0, 0, 0}; e = '{0, 0};
`ifdef HAZ_PERF_CNT_EN
            m_lu = 0; m_fm = 0; m_fw = 0;
`endif
        end else if (m) begin
            e = last_exp;
        end else if (f || st) begin
`ifdef HAZ_PERF_CNT_EN
            m_lu += st;
`endif
            in_mem = in_ex; in_ex = '{0, 0, 0, 0}; e = '{0, 0};
        end else begin
            e = iv ? '{src_of(s1, u1), src_of(s2, u2)} : '{0, 0};
`ifdef HAZ_PERF_CNT_EN
            m_fm += (e.s1 == 1) + (e.s2 == 1);
            m_fw += (e.s1 == 2) + (e.s2 == 2);
`endif
            in_mem = in_ex; in_ex = nw;
        end
        last_exp = e;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Shorthand for an ordinary cycle with both operands read.
    task automatic op(input int s1, input int s2, input int d, input bit l);
        step(0, 1, s1, s2, d, 1, l, 1, 1, 0, 0);
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel1", EX_forwarding_sel1, e.s1);
                chk("sel2", EX_forwarding_sel2, e.s2);
            end
        end
    end

    initial begin : stimulus
        in_ex = '{0, 0, 0, 0};
        in_mem = '{0, 0, 0, 0};
        do_reset();
`ifdef HAZ_PERF_CNT_EN
        chk("perf_lu_reset", perf_load_use_cnt, 0);
        chk("perf_fm_reset", perf_fwd_mem_cnt, 0);
        chk("perf_fw_reset", perf_fwd_wb_cnt, 0);
`endif
        // add x3 in EX, then add x4,x3,x5
        op(1, 2, 3, 0); op(3, 5, 4, 0); bubble();
        // add x3 reaches MEM, then sub x6,x1,x3
        op(1, 2, 3, 0); bubble(); op(1, 3, 6, 0); bubble();
        // lw x7 then add x8,x7,x7: one stall cycle, then WB forward on both
        op(1, 0, 7, 1); op(7, 7, 8, 0); op(7, 7, 8, 0); bubble();
        // x0 never forwards
        op(1, 0, 0, 0); op(0, 0, 10, 0); bubble();
        // x3 in EX and MEM: youngest wins; addi x9,x3,5 ignores rs2
        op(1, 2, 3, 0); op(1, 2, 3, 0); op(3, 3, 11, 0);
        step(0, 1, 3, 3, 9, 1, 0, 1, 0, 0, 0); bubble();
        // pending forward frozen for three mem_stall cycles
        op(1, 2, 3, 0); op(3, 3, 4, 0);
        repeat (3) step(0, 1, 3, 3, 12, 1, 1, 1, 1, 1, 1);
        op(3, 4, 13, 0); bubble();
        // flush beats a load-use hit
        op(1, 0, 7, 1); step(0, 1, 7, 7, 8, 1, 0, 1, 1, 1, 0); op(7, 2, 8, 0); bubble();
        // reset while a load-use stall is active
        op(1, 0, 7, 1); step(1, 1, 7, 7, 8, 1, 0, 1, 1, 0, 0); op(7, 7, 8, 0);
`ifdef HAZ_PERF_CNT_EN
        #1;
        chk("perf_lu_after_rst", perf_load_use_cnt, m_lu);
        chk("perf_fm_after_rst", perf_fwd_mem_cnt, m_fm);
`endif
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end
        bubble();
        #1;
`ifdef HAZ_PERF_CNT_EN
        chk("perf_load_use_cnt", perf_load_use_cnt, 32'(m_lu));
        chk("perf_fwd_mem_cnt", perf_fwd_mem_cnt, 32'(m_fm));
        chk("perf_fwd_wb_cnt", perf_fwd_wb_cnt, 32'(m_fw));
`endif
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
